// File: rtl/dmem_initiator_pkg.sv
// dmem_initiator_pkg: sign_mask/funct3 constants and FSM state type for the data memory initiator
package dmem_initiator_pkg;
  localparam logic [3:0] SM_LB  = 4'b1000;
  localparam logic [3:0] SM_LH  = 4'b1010;
  localparam logic [3:0] SM_LW  = 4'b0110;
  localparam logic [3:0] SM_LBU = 4'b0000;
  localparam logic [3:0] SM_LHU = 4'b0010;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {SYNC, IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP, ERR} state_t;
endpackage

// File: rtl/dmem_initiator_if.sv
// dmem_initiator_if: MEM-stage request/response and data memory port; master = initiator, slave = stage+memory side
interface dmem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_write_data;
  logic        dmem_memwrite;
  logic        dmem_memread;
  logic [3:0]  dmem_sign_mask;
  logic [31:0] dmem_read_data;
  logic        dmem_clk_stall;
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_read_data, dmem_clk_stall,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_write_data, dmem_memwrite, dmem_memread, dmem_sign_mask
  );
  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_read_data, dmem_clk_stall,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_write_data, dmem_memwrite, dmem_memread, dmem_sign_mask
  );
endinterface

// File: rtl/dmem_initiator_size_decode.sv
// dmem_initiator_size_decode: funct3/we/addr[1:0] -> sign_mask, misaligned, illegal (combinational)
module dmem_initiator_size_decode
  import dmem_initiator_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_we,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_sign_mask,
  output logic       o_misaligned,
  output logic       o_illegal
);
  logic [3:0] w_mask;
  logic       w_known;
  assign w_mask = i_funct3 == F3_B  ? SM_LB  :
                  i_funct3 == F3_H  ? SM_LH  :
                  i_funct3 == F3_W  ? SM_LW  :
                  i_funct3 == F3_BU ? SM_LBU :
                  i_funct3 == F3_HU ? SM_LHU : 4'b0000;
  assign w_known = i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  // stores only have the signed encodings; the unsigned ones are meaningless for them
  assign o_illegal = !w_known || (i_we && i_funct3[2]);
  assign o_sign_mask = i_we ? {1'b0, w_mask[2:0]} : w_mask;
  assign o_misaligned = (w_mask[2:1] == 2'b11 && i_addr_lo != 2'b00) || (w_mask[2:1] == 2'b01 && i_addr_lo[0]);
endmodule

// File: rtl/dmem_initiator.sv
// dmem_initiator: one-outstanding load/store initiator driving a stall-handshaked data memory
module dmem_initiator
  import dmem_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             rst_n,
  dmem_initiator_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic          r_to;
  logic [3:0]    w_mask;
  logic          w_mis;
  logic          w_ill;
  logic          w_accept;
  logic          w_hit;
  dmem_initiator_size_decode u_dec (
    .i_funct3    (bus.req_funct3),
    .i_we        (bus.req_we),
    .i_addr_lo   (bus.req_addr[1:0]),
    .o_sign_mask (w_mask),
    .o_misaligned(w_mis),
    .o_illegal   (w_ill)
  );
  assign bus.req_ready = (r_state == IDLE) & ~bus.dmem_clk_stall;
  assign w_accept = bus.req_valid & bus.req_ready;
  // r_cnt is 0 on the first cycle of a state, so this fires on its TIMEOUT_CYCLES-th cycle
  assign w_hit = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SYNC;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_to <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.dmem_addr <= '0;
      bus.dmem_write_data <= '0;
      bus.dmem_memwrite <= 1'b0;
      bus.dmem_memread <= 1'b0;
      bus.dmem_sign_mask <= '0;
    end else begin
      r_cnt <= r_cnt == CW'(TIMEOUT_CYCLES) ? r_cnt : r_cnt + 1'b1;
      bus.dmem_memread <= 1'b0;
      bus.dmem_memwrite <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      case (r_state)
        SYNC: if (bus.dmem_clk_stall == 1'b0) begin
          r_state <= IDLE;
          r_cnt <= '0;
        end
        IDLE: if (w_accept) begin
          r_cnt <= '0;
          r_we <= bus.req_we;
          r_to <= 1'b0;
          bus.dmem_addr <= bus.req_addr;
          bus.dmem_write_data <= bus.req_wdata;
          bus.dmem_sign_mask <= w_mask;
          if (w_mis | w_ill) begin
            r_state <= ERR;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            r_state <= ISSUE;
            bus.dmem_memread <= ~bus.req_we;
            bus.dmem_memwrite <= bus.req_we;
          end
        end
        ISSUE: begin
          r_state <= WAIT_HI;
          r_cnt <= '0;
        end
        WAIT_HI: if (bus.dmem_clk_stall) begin
          r_state <= WAIT_LO;
          r_cnt <= '0;
        end else if (w_hit) begin
          r_state <= ERR;
          r_cnt <= '0;
          r_to <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err <= 1'b1;
          bus.rsp_rdata <= '0;
        end
        WAIT_LO: if (!bus.dmem_clk_stall) begin
          r_state <= RESP;
          r_cnt <= '0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= r_we ? '0 : bus.dmem_read_data;
        end else if (w_hit) begin
          r_state <= ERR;
          r_cnt <= '0;
          r_to <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err <= 1'b1;
          bus.rsp_rdata <= '0;
        end
        RESP: begin
          r_state <= IDLE;
          r_cnt <= '0;
        end
        ERR: begin
          // after a timeout the memory may still be mid-access, so resynchronise on its stall
          r_state <= r_to ? SYNC : IDLE;
          r_cnt <= '0;
        end
        default: r_state <= SYNC;
      endcase
    end
  end
endmodule
